// File: rtl/i2c_slave_regfile_if.sv
// rtl/i2c_slave_regfile_if.sv - register-file port between the I2C target and local storage
interface i2c_slave_regfile_if #(
    parameter int PTR_W = 5
) ();
    logic [PTR_W-1:0] reg_addr;
    logic [7:0]       reg_wdata;
    logic             reg_we;
    logic [7:0]       reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        output reg_rdata
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target exposing an auto-incrementing register space
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         PTR_W      = 5,
    parameter int         FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_oe,
    output logic busy,
    output logic stop_det,
    i2c_slave_regfile_if.master rf
);
    localparam int              FC_W   = $clog2(FILTER_LEN + 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WR_DATA, ST_WR_ACK, ST_RD_LOAD, ST_RD_DATA, ST_RD_ACK
    } state_t;

    state_t state, state_n;

    logic scl_s1, scl_s2, sda_s1, sda_s2;
    logic fscl, fsda, fscl_d, fsda_d;
    logic [FC_W-1:0] scl_cnt, sda_cnt;
    logic [6:0] sr;
    logic [7:0] tx;
    logic [3:0] bit_cnt;
    logic       rw;

    logic oe_n, busy_n, stop_n, cnt_clr, shift_in, rw_load;
    logic ptr_load, ptr_inc, we_pulse, tx_load, tx_shift;

    // A filtered line only follows the synchronised pin after FILTER_LEN agreeing samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_s1  <= 1'b1;
            scl_s2  <= 1'b1;
            sda_s1  <= 1'b1;
            sda_s2  <= 1'b1;
            fscl    <= 1'b1;
            fsda    <= 1'b1;
            fscl_d  <= 1'b1;
            fsda_d  <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            if (scl_s2 != fscl) begin
                if (scl_cnt == FC_MAX) begin
                    fscl    <= scl_s2;
                    scl_cnt <= '0;
                end else begin
                    scl_cnt <= scl_cnt + 1'b1;
                end
            end else begin
                scl_cnt <= '0;
            end
            if (sda_s2 != fsda) begin
                if (sda_cnt == FC_MAX) begin
                    fsda    <= sda_s2;
                    sda_cnt <= '0;
                end else begin
                    sda_cnt <= sda_cnt + 1'b1;
                end
            end else begin
                sda_cnt <= '0;
            end
            fscl_d <= fscl;
            fsda_d <= fsda;
        end
    end

    wire scl_rise = fscl & ~fscl_d;
    wire scl_fall = ~fscl & fscl_d;
    wire sda_rise = fsda & ~fsda_d;
    wire sda_fall = ~fsda & fsda_d;
    wire start_c  = sda_fall & fscl;
    wire stop_c   = sda_rise & fscl;
    wire [7:0] byte_in = {sr, fsda};

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        oe_n     = sda_oe;
        busy_n   = busy;
        stop_n   = 1'b0;
        cnt_clr  = 1'b0;
        shift_in = 1'b0;
        rw_load  = 1'b0;
        ptr_load = 1'b0;
        ptr_inc  = 1'b0;
        we_pulse = 1'b0;
        tx_load  = 1'b0;
        tx_shift = 1'b0;
        if (stop_c) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            stop_n  = 1'b1;
        end else if (start_c) begin
            state_n = ST_ADDR;
            oe_n    = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                ST_ADDR: if (scl_rise) begin
                    shift_in = 1'b1;
                    if (bit_cnt == 4'd7) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                            busy_n  = 1'b1;
                            rw_load = 1'b1;
                            state_n = ST_ADDR_ACK;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end
                end
                // ACK states use sda_oe itself to tell the pull-low fall from the release fall.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_n = 1'b1;
                    end else begin
                        oe_n    = 1'b0;
                        cnt_clr = 1'b1;
                        if (state == ST_ADDR_ACK)
                            state_n = rw ? ST_RD_LOAD : ST_PTR;
                        else
                            state_n = ST_WR_DATA;
                        if (state == ST_WR_ACK)
                            ptr_inc = 1'b1;
                    end
                end
                ST_PTR: if (scl_rise) begin
                    shift_in = 1'b1;
                    if (bit_cnt == 4'd7) begin
                        ptr_load = 1'b1;
                        state_n  = ST_PTR_ACK;
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    shift_in = 1'b1;
                    if (bit_cnt == 4'd7) begin
                        we_pulse = 1'b1;
                        state_n  = ST_WR_ACK;
                    end
                end
                ST_RD_LOAD: begin
                    tx_load = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = ST_RD_DATA;
                end
                // The first bit goes out as soon as SCL is low; the rest follow each fall.
                ST_RD_DATA: begin
                    if (bit_cnt == 4'd0) begin
                        if (!fscl) begin
                            oe_n     = ~tx[7];
                            tx_shift = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            ptr_inc = 1'b1;
                            state_n = ST_RD_ACK;
                        end else begin
                            oe_n     = ~tx[7];
                            tx_shift = 1'b1;
                        end
                    end
                end
                ST_RD_ACK: if (scl_rise) begin
                    if (!fsda) begin
                        state_n = ST_RD_LOAD;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sda_oe       <= 1'b0;
            busy         <= 1'b0;
            stop_det     <= 1'b0;
            rw           <= 1'b0;
            sr           <= '0;
            tx           <= '0;
            bit_cnt      <= '0;
            rf.reg_addr  <= '0;
            rf.reg_wdata <= '0;
            rf.reg_we    <= 1'b0;
        end else begin
            sda_oe    <= oe_n;
            busy      <= busy_n;
            stop_det  <= stop_n;
            rf.reg_we <= we_pulse;
            if (cnt_clr)
                bit_cnt <= '0;
            else if (shift_in | tx_shift)
                bit_cnt <= bit_cnt + 1'b1;
            if (shift_in) sr <= byte_in[6:0];
            if (rw_load)  rw <= fsda;
            if (we_pulse) rf.reg_wdata <= byte_in;
            if (ptr_load)
                rf.reg_addr <= byte_in[PTR_W-1:0];
            else if (ptr_inc)
                rf.reg_addr <= rf.reg_addr + 1'b1;
            if (tx_load)
                tx <= rf.reg_rdata;
            else if (tx_shift)
                tx <= {tx[6:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - randomized bus-master bench with a register-space reference model
module tb_i2c_slave_regfile;
    localparam int Q = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic rd_xor = 1'b0;
    logic sda_oe0, busy0, stop_det0, sda_oe1, busy1, stop_det1;
    logic sda_bus;
    assign sda_bus = sda_m & ~sda_oe0 & ~sda_oe1;

    i2c_slave_regfile_if #(.PTR_W(5)) rf0 ();
    i2c_slave_regfile_if #(.PTR_W(3)) rf1 ();

    logic [7:0] mem0 [32] = '{default: 8'h00};
    logic [7:0] model_mem0 [32] = '{default: 8'h00};
    assign rf0.reg_rdata = rd_xor ? ({3'b000, rf0.reg_addr} ^ 8'h5A) : mem0[rf0.reg_addr];
    assign rf1.reg_rdata = 8'h00;

    i2c_slave_regfile #(.DEV_ADDR(7'h50), .PTR_W(5), .FILTER_LEN(3)) dut0 (
        .clk(clk), .reset(rst_n), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(sda_oe0), .busy(busy0), .stop_det(stop_det0), .rf(rf0)
    );
    i2c_slave_regfile #(.DEV_ADDR(7'h2A), .PTR_W(3), .FILTER_LEN(3)) dut1 (
        .clk(clk), .reset(rst_n), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(sda_oe1), .busy(busy1), .stop_det(stop_det1), .rf(rf1)
    );

    int total = 0;
    int bad = 0;
    int oe_cnt = 0, stop_cnt0 = 0, busy_cnt0 = 0;
    logic [16:0] act_q[$];
    logic [16:0] exp_q[$];
    int act_ptr = 0;
    logic [7:0] wbuf [16];

    always @(negedge clk) begin
        if (sda_oe0 | sda_oe1) oe_cnt++;
        if (stop_det0) stop_cnt0++;
        if (busy0) busy_cnt0++;
        if (rf0.reg_we) begin
            act_q.push_back({1'b0, 3'b000, rf0.reg_addr, rf0.reg_wdata});
            mem0[rf0.reg_addr] = rf0.reg_wdata;
        end
        if (rf1.reg_we) act_q.push_back({1'b1, 5'b00000, rf1.reg_addr, rf1.reg_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wclk(Q);
        scl_m = 1'b1; wclk(2 * Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(Q);
        b = sda_bus; wclk(Q);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        ack = ~a;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic check_writes;
        chk("wr_count", act_q.size() - act_ptr, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (act_ptr + i < act_q.size()) chk("wr_entry", act_q[act_ptr + i], exp_q[i]);
        act_ptr = act_q.size();
        exp_q.delete();
    endtask

    task automatic do_write(input int dut, input logic [7:0] ptr, input int n);
        logic ack;
        int depth, a, s0;
        depth = (dut == 1) ? 8 : 32;
        s0 = stop_cnt0;
        i2c_start;
        send_byte((dut == 1) ? 8'h54 : 8'hA0, ack);
        chk("wr_addr_ack", ack, 1);
        chk("busy_after_match", (dut == 1) ? busy1 : busy0, 1);
        send_byte(ptr, ack);
        chk("wr_ptr_ack", ack, 1);
        a = int'(ptr) % depth;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            chk("wr_data_ack", ack, 1);
            exp_q.push_back({dut[0], 8'(a), wbuf[i]});
            if (dut == 0) model_mem0[a] = wbuf[i];
            a = (a + 1) % depth;
        end
        i2c_stop;
        chk("stop_pulse_len", stop_cnt0 - s0, 1);
        chk("busy_after_stop", busy0 | busy1, 0);
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n);
        logic ack;
        logic [7:0] d, exp;
        int a;
        i2c_start;
        send_byte(8'hA0, ack); chk("rd_addr_ack", ack, 1);
        send_byte(ptr, ack);   chk("rd_ptr_ack", ack, 1);
        i2c_start;
        send_byte(8'hA1, ack); chk("rd_raddr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            recv_byte(d, i != n - 1);
            a = (int'(ptr) + i) % 32;
            exp = rd_xor ? (8'(a) ^ 8'h5A) : model_mem0[a];
            chk("rd_data", d, exp);
        end
        i2c_stop;
        chk("rd_end_ptr", rf0.reg_addr, (int'(ptr) + n) % 32);
        chk("rd_busy_end", busy0, 0);
    endtask

    task automatic chk_reset_vals;
        chk("rst_sda_oe", sda_oe0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_stop_det", stop_det0, 0);
        chk("rst_reg_addr", rf0.reg_addr, 0);
        chk("rst_reg_we", rf0.reg_we, 0);
        chk("rst_reg_wdata", rf0.reg_wdata, 0);
        chk("rst_sda_oe1", sda_oe1, 0);
    endtask

    initial begin
        logic ack;
        int o, s, b, n;
        wclk(5);
        chk_reset_vals;
        rst_n = 1'b1;
        wclk(5);

        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        do_write(0, 8'h03, 2);
        check_writes;

        o = oe_cnt;
        b = busy_cnt0;
        i2c_start;
        send_byte(8'hA2, ack);
        chk("mismatch_nack", ack, 0);
        send_byte(8'h05, ack);
        i2c_stop;
        chk("mismatch_oe", oe_cnt - o, 0);
        chk("mismatch_busy", busy_cnt0 - b, 0);
        check_writes;

        rd_xor = 1'b1;
        do_read(8'h1F, 3);
        rd_xor = 1'b0;

        o = oe_cnt;
        s = stop_cnt0;
        sda_m = 1'b0; wclk(2);
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b0; wclk(Q);
        send_byte(8'hA0, ack);
        chk("glitch_no_ack", ack, 0);
        chk("glitch_oe", oe_cnt - o, 0);
        chk("glitch_no_stop", stop_cnt0 - s, 0);
        chk("glitch_busy", busy0, 0);
        i2c_stop;

        i2c_start;
        send_byte(8'hA0, ack); chk("abort_addr_ack", ack, 1);
        send_byte(8'h08, ack); chk("abort_ptr_ack", ack, 1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        i2c_stop;
        check_writes;
        chk("abort_busy", busy0, 0);

        rd_xor = 1'b1;
        i2c_start;
        send_byte(8'hA0, ack);
        send_byte(8'h04, ack);
        i2c_start;
        send_byte(8'hA1, ack);
        chk("rrst_addr_ack", ack, 1);
        for (int k = 0; k < 40 && !sda_oe0; k++) wclk(1);
        chk("rrst_drive_low", sda_oe0, 1);
        rst_n = 1'b0;
        wclk(1);
        chk_reset_vals;
        rst_n = 1'b1;
        wclk(2);
        i2c_stop;
        rd_xor = 1'b0;

        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(0, 8'($urandom), n);
            check_writes;
            do_read(8'($urandom), $urandom_range(1, 4));
        end

        for (int i = 0; i < 9; i++) wbuf[i] = 8'($urandom);
        do_write(1, 8'h06, 9);
        check_writes;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
